multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle sequencer for the single-issue MIPS datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states and drives the PC, instruction-register, ALU-operand, data-memory and register-file controls one phase at a time, so that one instruction memory, one data memory and one ALU are reused across cycles. It supports R-type (0x00), LW (0x23), SW (0x2B), BEQ (0x04) and J (0x02), with ready handshakes and timeout detection on both memories.

## Interface
- MEM_TIMEOUT, 15: maximum wait cycles for `imem_ready`/`dmem_ready` before a fault.
- RETIRE_W, 16: width of the retired-instruction counter.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- run  in  1  enables instruction issue.
- opcode  in  6  IR[31:26], held stable by the IR from DECODE until retire.
- zero_out  in  1  ALU zero flag.
- imem_ready  in  1  instruction word valid.
- dmem_ready  in  1  data access complete.
- imem_req  out  1  instruction fetch request.
- ir_load  out  1  IR capture strobe.
- pc_write_en  out  1  PC update strobe.
- pc_sel  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
- alu_src_sel  out  1  ALU operand 2 source: 1 = sign-extended immediate, 0 = rs2 data.
- dmem_read_en  out  1  data-memory read.
- dmem_write_en  out  1  data-memory write.
- reg_write_en  out  1  register-file write.
- reg_dst_sel  out  1  write address: 1 = IR[15:11], 0 = IR[20:16].
- wb_sel  out  1  write-back data: 1 = memory read data, 0 = ALU result.
- instr_retired  out  1  one-cycle pulse when an instruction completes.
- retired_count  out  RETIRE_W  retired-instruction count; wraps to 0.
- illegal_op  out  1  sticky unknown-opcode fault.
- timeout  out  1  sticky memory-timeout fault.
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.

## Operation

**Registers and outputs**
- Registered: `state`, wait counter, `retired_count`, `illegal_op`, `timeout`.
- All other outputs are combinational from `state`, `opcode`, `zero_out` and the ready inputs.
- Any output not asserted by the rules below is 0.

**"Next" destination**
- After retire, go to FETCH if `run`=1, otherwise IDLE.

**State transitions**
- IDLE: go to FETCH when `run`=1.
- FETCH:
  - `imem_req`=1.
  - On `imem_ready`: `ir_load`=1 that cycle, go to DECODE.
- DECODE:
  - Unknown opcode: go to HALT and set `illegal_op`.
  - J: `pc_write_en`=1, `pc_sel`=10, retire, go to next.
  - All other legal opcodes: go to EXEC.
- EXEC:
  - R-type: go to WB.
  - LW/SW: `alu_src_sel`=1, go to MEM.
  - BEQ: `pc_write_en`=1, `pc_sel`=01 if `zero_out` else 00, retire, go to next.
- MEM:
  - `alu_src_sel`=1 throughout.
  - LW holds `dmem_read_en`=1; SW holds `dmem_write_en`=1, until `dmem_ready`.
  - On `dmem_ready`, SW: `pc_write_en`=1, `pc_sel`=00, retire, go to next.
  - On `dmem_ready`, LW: go to WB.
- WB:
  - `reg_write_en`=1.
  - `reg_dst_sel`=1 for R-type, 0 for LW.
  - `wb_sel`=1 for LW, 0 for R-type.
  - `alu_src_sel`=1 for LW.
  - `pc_write_en`=1, `pc_sel`=00, retire, go to next.
- HALT:
  - All strobes 0.
  - Exit only through `reset`.

**Retire**
- `instr_retired`=1 for one cycle.
- `retired_count` increments at the same clock edge.

**Wait counter**
- Cleared on entry to FETCH or MEM; increments each cycle that ready is low.
- If ready is still low when the counter equals MEM_TIMEOUT: go to HALT, set `timeout`.
- Ready arriving in the same cycle that the count reaches MEM_TIMEOUT takes priority; no fault.

**Other rules**
- `run` is sampled only in IDLE and at retire. Dropping `run` mid-instruction completes that instruction first.

## Timing
- Reset (asynchronous): `state`=IDLE, counter=0, `retired_count`=0, `illegal_op`=0, `timeout`=0. All outputs read 0 while `reset` is high.
- Clock cycles per instruction with zero-wait memories (ready in the request cycle), counted from FETCH entry: J 2, BEQ 3, R-type 4, SW 4, LW 5.
- Each memory wait cycle adds 1 cycle.
- Back-to-back instructions: FETCH begins the cycle after the retire edge; there are no idle bubbles while `run`=1.
- Strobes last exactly one cycle: `ir_load`, `pc_write_en`, `reg_write_en`, `instr_retired`.
- Memory enables stay high every cycle of MEM until ready.
- Reset asserted mid-instruction aborts the instruction immediately; no further strobes are issued.
- `retired_count` wraps from 2^RETIRE_W−1 to 0.

## Test plan
- **Reset and idle.** Reset, `run`=1, zero-wait memories, opcode 0x00 → `state` 0→1→2→3→5→1. `reg_write_en` and `reg_dst_sel`=1 in WB. `retired_count`=1 after 4 cycles.
- **LW with data wait.** LW with `dmem_ready` delayed 3 cycles → `dmem_read_en` high for 4 MEM cycles, then WB with `wb_sel`=1 and `reg_dst_sel`=0. Total 8 cycles.
- **Branches.** BEQ with `zero_out`=1, then BEQ with `zero_out`=0 → `pc_sel`=01, then 00, each in EXEC. 3 cycles each.
- **J and SW.** J retires in DECODE with `pc_sel`=10. SW asserts `dmem_write_en` and retires in MEM with `reg_write_en` never high.
- **Faults.** Opcode 0x3F → HALT, `illegal_op`=1, strobes 0 until reset. `imem_ready` held low → HALT with `timeout`=1 after MEM_TIMEOUT+1 FETCH cycles. Ready exactly at count MEM_TIMEOUT → no fault.
- **Run and wrap.** Drop `run` during an LW's MEM state → LW completes, then IDLE. With RETIRE_W=2, 4 retires → `retired_count` wraps to 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for a single-issue MIPS datapath.
// Drives per-phase datapath strobes with ready handshakes and memory-timeout detection.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned RETIRE_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                run_i,
    input  logic [5:0]          opcode_i,
    input  logic                zero_out_i,
    input  logic                imem_ready_i,
    input  logic                dmem_ready_i,
    output logic                imem_req_o,
    output logic                ir_load_o,
    output logic                pc_write_en_o,
    output logic [1:0]          pc_sel_o,
    output logic                alu_src_sel_o,
    output logic                dmem_read_en_o,
    output logic                dmem_write_en_o,
    output logic                reg_write_en_o,
    output logic                reg_dst_sel_o,
    output logic                wb_sel_o,
    output logic                instr_retired_o,
    output logic [RETIRE_W-1:0] retired_count_o,
    output logic                illegal_op_o,
    output logic                timeout_o,
    output logic [2:0]          state_o
);

    localparam int unsigned CntW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(MEM_TIMEOUT);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpJ     = 6'h02;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [RETIRE_W-1:0] retired_count_q, retired_count_d;
    logic                illegal_q, illegal_d;
    logic                timeout_q, timeout_d;
    logic                retire;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        illegal_d       = illegal_q;
        timeout_d       = timeout_q;
        retire          = 1'b0;
        imem_req_o      = 1'b0;
        ir_load_o       = 1'b0;
        pc_write_en_o   = 1'b0;
        pc_sel_o        = 2'b00;
        alu_src_sel_o   = 1'b0;
        dmem_read_en_o  = 1'b0;
        dmem_write_en_o = 1'b0;
        reg_write_en_o  = 1'b0;
        reg_dst_sel_o   = 1'b0;
        wb_sel_o        = 1'b0;

        case (state_q)
            StIdle: begin
                if (run_i) begin
                    state_d = StFetch;
                    cnt_d   = '0;
                end
            end
            StFetch: begin
                imem_req_o = 1'b1;
                // Ready on the final count still wins over the fault.
                if (imem_ready_i) begin
                    ir_load_o = 1'b1;
                    state_d   = StDecode;
                end else if (cnt_q == TimeoutVal) begin
                    state_d   = StHalt;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDecode: begin
                case (opcode_i)
                    OpJ: begin
                        pc_write_en_o = 1'b1;
                        pc_sel_o      = 2'b10;
                        retire        = 1'b1;
                    end
                    OpRtype, OpLw, OpSw, OpBeq: state_d = StExec;
                    default: begin
                        state_d   = StHalt;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StExec: begin
                case (opcode_i)
                    OpRtype: state_d = StWb;
                    OpLw, OpSw: begin
                        alu_src_sel_o = 1'b1;
                        state_d       = StMem;
                        cnt_d         = '0;
                    end
                    OpBeq: begin
                        pc_write_en_o = 1'b1;
                        pc_sel_o      = zero_out_i ? 2'b01 : 2'b00;
                        retire        = 1'b1;
                    end
                    default: begin
                        state_d   = StHalt;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMem: begin
                alu_src_sel_o   = 1'b1;
                dmem_read_en_o  = (opcode_i == OpLw);
                dmem_write_en_o = (opcode_i != OpLw);
                if (dmem_ready_i) begin
                    if (opcode_i == OpLw) begin
                        state_d = StWb;
                    end else begin
                        pc_write_en_o = 1'b1;
                        retire        = 1'b1;
                    end
                end else if (cnt_q == TimeoutVal) begin
                    state_d   = StHalt;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWb: begin
                reg_write_en_o = 1'b1;
                reg_dst_sel_o  = (opcode_i == OpRtype);
                wb_sel_o       = (opcode_i == OpLw);
                alu_src_sel_o  = (opcode_i == OpLw);
                pc_write_en_o  = 1'b1;
                retire         = 1'b1;
            end
            StHalt: state_d = StHalt;
            default: state_d = StHalt;
        endcase

        // run is sampled at retire so a dropped run still lets the instruction finish.
        if (retire) begin
            state_d = run_i ? StFetch : StIdle;
            cnt_d   = '0;
        end
        retired_count_d = retired_count_q + RETIRE_W'(retire);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            retired_count_q <= '0;
            illegal_q       <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            retired_count_q <= retired_count_d;
            illegal_q       <= illegal_d;
            timeout_q       <= timeout_d;
        end
    end

    assign instr_retired_o = retire;
    assign retired_count_o = retired_count_q;
    assign illegal_op_o    = illegal_q;
    assign timeout_o       = timeout_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus a randomized
// instruction stream checked against a per-instruction transaction model.
module tb_multicycle_controller;

    localparam int unsigned MT = 15;
    localparam int unsigned RW = 2;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_J   = 6'h02;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          run = 1'b0;
    logic [5:0]    opcode = 6'h00;
    logic          zero = 1'b0;
    logic          imem_rdy = 1'b0;
    logic          dmem_rdy = 1'b0;
    logic          imem_req, ir_load, pc_write, alu_src, drd, dwr, rwr, rdst, wbsel, ret;
    logic          illegal, tmo;
    logic [1:0]    pc_sel;
    logic [RW-1:0] rcount;
    logic [2:0]    state;
    logic [11:0]   strobes;

    int checks = 0;
    int errors = 0;
    int model_count = 0;

    assign strobes = {imem_req, ir_load, pc_write, pc_sel, alu_src, drd, dwr, rwr, rdst, wbsel, ret};

    multicycle_controller #(
        .MEM_TIMEOUT(MT),
        .RETIRE_W   (RW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .run_i          (run),
        .opcode_i       (opcode),
        .zero_out_i     (zero),
        .imem_ready_i   (imem_rdy),
        .dmem_ready_i   (dmem_rdy),
        .imem_req_o     (imem_req),
        .ir_load_o      (ir_load),
        .pc_write_en_o  (pc_write),
        .pc_sel_o       (pc_sel),
        .alu_src_sel_o  (alu_src),
        .dmem_read_en_o (drd),
        .dmem_write_en_o(dwr),
        .reg_write_en_o (rwr),
        .reg_dst_sel_o  (rdst),
        .wb_sel_o       (wbsel),
        .instr_retired_o(ret),
        .retired_count_o(rcount),
        .illegal_op_o   (illegal),
        .timeout_o      (tmo),
        .state_o        (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one cycle after reset release with run=1, i.e. in FETCH.
    task automatic do_reset();
        rst = 1'b1;
        imem_rdy = 1'b0;
        dmem_rdy = 1'b0;
        step();
        rst = 1'b0;
        run = 1'b1;
        model_count = 0;
        step();
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL reset_to_fetch: got state %0d, want 1", state);
        end
    endtask

    task automatic test_reset();
        run = 1'b1;
        opcode = OP_R;
        imem_rdy = 1'b1;
        dmem_rdy = 1'b1;
        zero = 1'b1;
        #3;
        rst = 1'b1;
        #2;
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d, want 0", state);
        end
        checks++;
        if (strobes !== 12'h000) begin
            errors++;
            $display("FAIL reset_strobes: got %h, want 000", strobes);
        end
        checks++;
        if ({rcount, illegal, tmo} !== '0) begin
            errors++;
            $display("FAIL reset_regs: got count %0d illegal %b timeout %b, want 0", rcount,
                     illegal, tmo);
        end
        do_reset();
    endtask

    task automatic test_rtype_trace();
        int exp_st[4] = '{1, 2, 3, 5};
        int bad = 0;
        opcode = OP_R;
        imem_rdy = 1'b1;
        dmem_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (state !== 3'(exp_st[i])) bad++;
            if (exp_st[i] == 5 && !(rwr === 1'b1 && rdst === 1'b1)) bad++;
            step();
        end
        imem_rdy = 1'b0;
        dmem_rdy = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rtype_trace: got %0d bad cycles, want 0", bad);
        end
        model_count = 1;
        checks++;
        if (state !== 3'd1 || rcount !== 2'd1) begin
            errors++;
            $display("FAIL rtype_retire: got state %0d count %0d, want 1 1", state, rcount);
        end
    endtask

    // Runs one instruction from FETCH and checks it against the transaction-level model.
    task automatic run_instr(input logic [5:0] op, input logic z, input int wi, input int wd,
                             input bit drop);
        int cyc = 0, fwait = 0, dwait = 0;
        int n_ir = 0, n_pcw = 0, n_rw = 0, n_rd = 0, n_wr = 0;
        int exp_cyc, exp_rw, exp_rd, exp_wr;
        logic [1:0] exp_sel;
        logic [1:0] got_sel = 2'bxx;
        logic got_dst = 1'bx, got_wb = 1'bx;
        logic [RW-1:0] exp_cnt;
        bit done = 0;
        opcode = op;
        zero = z;
        case (op)
            OP_J:    exp_cyc = 2 + wi;
            OP_BEQ:  exp_cyc = 3 + wi;
            OP_R:    exp_cyc = 4 + wi;
            OP_SW:   exp_cyc = 4 + wi + wd;
            default: exp_cyc = 5 + wi + wd;
        endcase
        exp_rw  = (op == OP_R || op == OP_LW) ? 1 : 0;
        exp_rd  = (op == OP_LW) ? wd + 1 : 0;
        exp_wr  = (op == OP_SW) ? wd + 1 : 0;
        exp_sel = (op == OP_J) ? 2'b10 : ((op == OP_BEQ && z) ? 2'b01 : 2'b00);
        while (!done && cyc < 64) begin
            imem_rdy = imem_req && (fwait == wi);
            dmem_rdy = (drd || dwr) && (dwait == wd);
            #1;
            cyc++;
            if (imem_req && !imem_rdy) fwait++;
            if ((drd || dwr) && !dmem_rdy) dwait++;
            n_ir  += int'(ir_load);
            n_pcw += int'(pc_write);
            n_rw  += int'(rwr);
            n_rd  += int'(drd);
            n_wr  += int'(dwr);
            if (pc_write) got_sel = pc_sel;
            if (rwr) begin
                got_dst = rdst;
                got_wb  = wbsel;
            end
            if (drop && drd) run = 1'b0;
            if (ret) done = 1;
            step();
        end
        imem_rdy = 1'b0;
        dmem_rdy = 1'b0;
        checks++;
        if (!done || cyc != exp_cyc) begin
            errors++;
            $display("FAIL cycles op=%h: got %0d (retired %0d), want %0d", op, cyc, done,
                     exp_cyc);
        end
        checks++;
        if (n_ir != 1 || n_pcw != 1 || got_sel !== exp_sel) begin
            errors++;
            $display("FAIL pc_ctrl op=%h: got ir %0d pcw %0d sel %b, want 1 1 %b", op, n_ir,
                     n_pcw, got_sel, exp_sel);
        end
        checks++;
        if (n_rw != exp_rw || (exp_rw == 1 &&
            (got_dst !== (op == OP_R) || got_wb !== (op == OP_LW)))) begin
            errors++;
            $display("FAIL writeback op=%h: got rw %0d dst %b wb %b, want rw %0d", op, n_rw,
                     got_dst, got_wb, exp_rw);
        end
        checks++;
        if (n_rd != exp_rd || n_wr != exp_wr) begin
            errors++;
            $display("FAIL dmem_en op=%h: got rd %0d wr %0d, want %0d %0d", op, n_rd, n_wr,
                     exp_rd, exp_wr);
        end
        model_count = (model_count + 1) % (1 << RW);
        exp_cnt = model_count[RW-1:0];
        checks++;
        if (rcount !== exp_cnt || state !== (drop ? 3'd0 : 3'd1)) begin
            errors++;
            $display("FAIL after_retire op=%h: got count %0d state %0d, want %0d %0d", op,
                     rcount, state, exp_cnt, drop ? 0 : 1);
        end
    endtask

    task automatic test_lw_wait();
        run_instr(OP_LW, 1'b0, 0, 3, 1'b0);
    endtask

    task automatic test_branches();
        run_instr(OP_BEQ, 1'b1, 0, 0, 1'b0);
        run_instr(OP_BEQ, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_j_sw();
        run_instr(OP_J, 1'b0, 0, 0, 1'b0);
        run_instr(OP_SW, 1'b1, 1, 2, 1'b0);
    endtask

    task automatic test_ready_at_limit();
        run_instr(OP_R, 1'b0, MT, 0, 1'b0);
        run_instr(OP_SW, 1'b0, 0, MT, 1'b0);
        checks++;
        if (tmo !== 1'b0) begin
            errors++;
            $display("FAIL ready_at_limit: got timeout %b, want 0", tmo);
        end
    endtask

    task automatic test_run_drop();
        run_instr(OP_LW, 1'b0, 1, 2, 1'b1);
        step();
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL idle_hold: got state %0d, want 0", state);
        end
        run = 1'b1;
        step();
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL idle_to_fetch: got state %0d, want 1", state);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 4; i++) run_instr(OP_J, 1'b0, 0, 0, 1'b0);
        checks++;
        if (rcount !== 2'd0) begin
            errors++;
            $display("FAIL count_wrap: got %0d, want 0", rcount);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[5] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J};
        for (int i = 0; i < 40; i++) begin
            run_instr(ops[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
        end
    endtask

    task automatic test_illegal();
        int bad = 0;
        opcode = 6'h3F;
        imem_rdy = 1'b1;
        step();
        step();
        checks++;
        if (state !== 3'd6 || illegal !== 1'b1 || tmo !== 1'b0) begin
            errors++;
            $display("FAIL illegal_halt: got state %0d illegal %b timeout %b, want 6 1 0",
                     state, illegal, tmo);
        end
        dmem_rdy = 1'b1;
        zero = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (strobes !== 12'h000 || state !== 3'd6) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL halt_quiet: got %0d noisy cycles, want 0", bad);
        end
        do_reset();
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear: got %b, want 0", illegal);
        end
    endtask

    task automatic test_timeout();
        int fetch_cyc = 0;
        opcode = OP_R;
        imem_rdy = 1'b0;
        while (state == 3'd1 && fetch_cyc < 40) begin
            fetch_cyc++;
            step();
        end
        checks++;
        if (fetch_cyc != MT + 1 || state !== 3'd6 || tmo !== 1'b1 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL imem_timeout: got %0d cycles state %0d timeout %b, want %0d 6 1",
                     fetch_cyc, state, tmo, MT + 1);
        end
        do_reset();
    endtask

    task automatic test_reset_abort();
        int guard = 0;
        opcode = OP_LW;
        imem_rdy = 1'b1;
        dmem_rdy = 1'b0;
        while (!drd && guard < 6) begin
            step();
            imem_rdy = 1'b0;
            guard++;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (guard >= 6 || strobes !== 12'h000 || state !== 3'd0) begin
            errors++;
            $display("FAIL reset_abort: got strobes %h state %0d, want 000 0", strobes, state);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_rtype_trace();
        test_lw_wait();
        test_branches();
        test_j_sw();
        test_ready_at_limit();
        test_run_drop();
        test_wrap();
        test_random();
        test_illegal();
        test_timeout();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
